vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines.
- HFP, 40, horizontal front porch.
- HPULSE, 48, horizontal sync width.
- HBP, 40, horizontal back porch.
- VFP, 13, vertical front porch.
- VPULSE, 3, vertical sync width.
- VBP, 29, vertical back porch.
- HS_POL, 0, HS active level.
- VS_POL, 0, VS active level.
- GRID, 16, grid pitch in pixels.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- pixel_clk, in, 1, sole clock.
- pixel_rst, in, 1, reset; synchronous, active-high.
- pattern_sel, in, 2, pattern select: 0 external, 1 grid, 2 colour bars, 3 black.
- pix_data, in, 24, external RGB888, sampled when pix_req=1.
- pix_req, out, 1, external pixel request.
- req_x, out, clog2(HDISP), x of the requested pixel.
- req_y, out, clog2(VDISP), y of the requested pixel.
- frame_start, out, 1, one-cycle pulse at the first active pixel request of each frame.
- video_ifm, video_if.master, -, drives CLK, HS, VS, BLANK and RGB[23:0].
REQ-003 video_ifm.CLK SHALL be driven directly by pixel_clk.

Function
REQ-004 HTOTAL=HDISP+HFP+HPULSE+HBP and VTOTAL=VDISP+VFP+VPULSE+VBP; counter widths SHALL be clog2(HTOTAL) and clog2(VTOTAL).
REQ-005 h_cnt SHALL count 0..HTOTAL-1 and wrap to 0; v_cnt SHALL increment only when h_cnt wraps and SHALL wrap from VTOTAL-1 to 0.
REQ-006 Regions per axis, in order: front porch [0,FP), sync [FP,FP+PULSE), back porch [FP+PULSE,FP+PULSE+BP), active [FP+PULSE+BP,TOTAL).
REQ-007 Stage 1, registered one cycle after the counters:
- pix_req=1 iff both counters are in their active regions.
- req_x=h_cnt-(HFP+HPULSE+HBP) and req_y=v_cnt-(VFP+VPULSE+VBP) when pix_req=1, else 0.
- frame_start=pix_req AND req_x=0 AND req_y=0.
REQ-008 Stage 2, registered one cycle after stage 1:
- HS=HS_POL while h_cnt is in sync, else ~HS_POL; VS likewise with VS_POL.
- BLANK=1 in active video only (BLANK high means display).
- RGB per the latched pattern; RGB=0 whenever BLANK=0.
- HS, VS, BLANK and RGB SHALL be mutually aligned: total latency 2 cycles from the counters.
REQ-009 Patterns, evaluated on stage-1 coordinates:
- 0: pix_data captured at the pix_req cycle.
- 1: 24'hFFFFFF if req_x%GRID==0 or req_y%GRID==0, else 0.
- 2: eight vertical bars of width HDISP/8 in the order white, yellow, cyan, green, magenta, red, blue, black; the last bar absorbs any remainder.
- 3: 0.
REQ-010 pattern_sel SHALL be latched only when h_cnt=0 and v_cnt=0; a mid-frame change SHALL take effect from the next frame.
REQ-011 pix_data SHALL be ignored in cycles where pix_req=0.

Reset
REQ-012 While pixel_rst=1 at a rising edge:
- h_cnt=0 and v_cnt=0.
- pix_req=0, req_x=0, req_y=0, frame_start=0.
- HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0.
- latched pattern=0.
REQ-013 Reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL have h_cnt=0 and v_cnt=0, with no partial-line output.

Configuration
REQ-014 With VGA_TESTPATTERN_EN defined, patterns 1-3 SHALL be implemented per REQ-009.
REQ-015 With VGA_TESTPATTERN_EN undefined:
- pattern_sel and its latch SHALL be absent from logic.
- RGB SHALL always be the external pixel (pattern 0).
- Timing and latency SHALL be unchanged.

Structure
REQ-016 Package vga_pkg SHALL hold the pattern_sel enum (PAT_EXT, PAT_GRID, PAT_BARS, PAT_BLACK), the colour-bar constant array and an RGB888 typedef.
REQ-017 The pattern generator SHALL be sub-module vga_pattern (combinational on coordinates, pattern and pix_data), instantiated only under VGA_TESTPATTERN_EN.

Verification
Bench parameters: HDISP=8, VDISP=4, HFP=2, HPULSE=2, HBP=2, VFP=1, VPULSE=1, VBP=1, giving HTOTAL=14, VTOTAL=7 and 98 cycles per frame.
REQ-018 Reset release, then run 2 frames -> HS low for 2 of every 14 cycles starting 4 cycles after release; VS low for 14 cycles per frame; BLANK high for 8 cycles on each of 4 lines; frame period exactly 98 cycles.
REQ-019 Counter index 48 (v=3, h=6) -> pix_req rises 1 cycle later with req_x=0, req_y=0 and frame_start=1; BLANK rises 2 cycles after index 48.
REQ-020 pattern_sel=0 and pix_data=req_x*16+req_y -> RGB matches that value 1 cycle after each request; RGB=0 when BLANK=0.
REQ-021 GRID=4, pattern_sel=1 -> the RGB line at req_y=1 is FFFFFF, 0, 0, 0, FFFFFF, 0, 0, 0.
REQ-022 pattern_sel changed from 0 to 2 at mid-frame -> the current frame stays external; bars start at the next frame's first pixel (FFFFFF, then FFFF00, ...).
REQ-023 pixel_rst pulsed at index 50 -> all outputs at their REQ-012 values the next cycle; the timing of REQ-018 resumes from index 0 after release.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared pattern enum, colour-bar table and pixel type
package vga_pkg;

    typedef logic [23:0] rgb888_t;

    typedef enum logic [1:0] {
        PAT_EXT   = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_BLACK = 2'd3
    } pattern_e;

    // Left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam rgb888_t BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/video_if.sv
// rtl/video_if.sv - parallel RGB video output bundle
interface video_if;

    logic        CLK;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;

    modport master (output CLK, output HS, output VS, output BLANK, output RGB);
    modport slave  (input  CLK, input  HS, input  VS, input  BLANK, input  RGB);

endinterface

// File: rtl/vga_pattern.sv
// rtl/vga_pattern.sv - combinational test-pattern colour for one active pixel
module vga_pattern
    import vga_pkg::*;
#(
    parameter int          HDISP = 800,
    parameter int          VDISP = 480,
    parameter int unsigned GRID  = 16
) (
    input  logic [$clog2(HDISP)-1:0] i_x,
    input  logic [$clog2(VDISP)-1:0] i_y,
    input  pattern_e                 i_pattern,
    input  rgb888_t                  i_pix_data,
    output rgb888_t                  o_rgb
);

    // Narrow displays still get eight bars; the last one takes the remainder
    localparam int unsigned BAR_W = (HDISP >= 8) ? HDISP / 8 : 1;

    int unsigned w_bar;

    always_comb begin
        o_rgb = '0;
        w_bar = 32'(i_x) / BAR_W;
        if (w_bar > 32'd7) begin
            w_bar = 32'd7;
        end
        case (i_pattern)
            PAT_EXT:  o_rgb = i_pix_data;
            PAT_GRID: begin
                if (((32'(i_x) % GRID) == 32'd0) || ((32'(i_y) % GRID) == 32'd0)) begin
                    o_rgb = 24'hFFFFFF;
                end
            end
            PAT_BARS: o_rgb = BAR_COLOURS[w_bar[2:0]];
            default:  o_rgb = '0;
        endcase
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/blank timing with a two-stage pixel pipeline
// Test patterns 1-3 and the pattern_sel latch exist only with VGA_TESTPATTERN_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int GRID   = 16
) (
    input  logic                     pixel_clk,
    input  logic                     pixel_rst,
    input  logic [1:0]               pattern_sel,
    input  logic [23:0]              pix_data,
    output logic                     pix_req,
    output logic [$clog2(HDISP)-1:0] req_x,
    output logic [$clog2(VDISP)-1:0] req_y,
    output logic                     frame_start,
    video_if.master                  video_ifm
);

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);
    localparam int HACT   = HFP + HPULSE + HBP;
    localparam int VACT   = VFP + VPULSE + VBP;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_h_sync;
    logic w_v_sync;

    assign w_h_wrap = (r_h_cnt == HW'(HTOTAL - 1));
    assign w_v_wrap = (r_v_cnt == VW'(VTOTAL - 1));
    assign w_active = (r_h_cnt >= HW'(HACT)) && (r_v_cnt >= VW'(VACT));
    assign w_h_sync = (r_h_cnt >= HW'(HFP)) && (r_h_cnt < HW'(HFP + HPULSE));
    assign w_v_sync = (r_v_cnt >= VW'(VFP)) && (r_v_cnt < VW'(VFP + VPULSE));

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    logic          r_pix_req;
    logic [XW-1:0] r_req_x;
    logic [YW-1:0] r_req_y;
    logic          r_frame_start;
    logic          r_s1_hsync;
    logic          r_s1_vsync;

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_pix_req     <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_frame_start <= 1'b0;
            r_s1_hsync    <= 1'b0;
            r_s1_vsync    <= 1'b0;
        end else begin
            r_pix_req     <= w_active;
            r_req_x       <= w_active ? XW'(r_h_cnt - HW'(HACT)) : '0;
            r_req_y       <= w_active ? YW'(r_v_cnt - VW'(VACT)) : '0;
            r_frame_start <= w_active && (r_h_cnt == HW'(HACT)) && (r_v_cnt == VW'(VACT));
            r_s1_hsync    <= w_h_sync;
            r_s1_vsync    <= w_v_sync;
        end
    end

    rgb888_t w_rgb;

`ifdef VGA_TESTPATTERN_EN
    pattern_e r_pattern;

    // Latched at the frame origin so a pattern never changes mid-frame
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_pattern <= PAT_EXT;
        end else if ((r_h_cnt == '0) && (r_v_cnt == '0)) begin
            r_pattern <= pattern_e'(pattern_sel);
        end
    end

    vga_pattern #(
        .HDISP (HDISP),
        .VDISP (VDISP),
        .GRID  (GRID)
    ) u_pattern (
        .i_x        (r_req_x),
        .i_y        (r_req_y),
        .i_pattern  (r_pattern),
        .i_pix_data (pix_data),
        .o_rgb      (w_rgb)
    );
`else
    logic w_unused_pattern_sel;
    assign w_unused_pattern_sel = ^pattern_sel;
    assign w_rgb                = pix_data;
`endif

    logic    r_hs;
    logic    r_vs;
    logic    r_blank;
    rgb888_t r_rgb;

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            r_hs    <= ~HS_POL;
            r_vs    <= ~VS_POL;
            r_blank <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hs    <= r_s1_hsync ? HS_POL : ~HS_POL;
            r_vs    <= r_s1_vsync ? VS_POL : ~VS_POL;
            r_blank <= r_pix_req;
            r_rgb   <= r_pix_req ? w_rgb : '0;
        end
    end

    assign pix_req         = r_pix_req;
    assign req_x           = r_req_x;
    assign req_y           = r_req_y;
    assign frame_start     = r_frame_start;

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.HS    = r_hs;
    assign video_ifm.VS    = r_vs;
    assign video_ifm.BLANK = r_blank;
    assign video_ifm.RGB   = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

`ifdef VGA_TESTPATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    localparam int HT    = 14;
    localparam int FRAME = 98;

    localparam logic [23:0] BAR_LIT [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
    localparam logic [23:0] GRID_ROW1 [8] = '{
        24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pattern_sel;
    logic [23:0] pix_data;
    logic        pix_req;
    logic [2:0]  req_x;
    logic [1:0]  req_y;
    logic        frame_start;

    video_if u_vif ();

    vga_timing_gen #(
        .HDISP  (8),
        .VDISP  (4),
        .HFP    (2),
        .HPULSE (2),
        .HBP    (2),
        .VFP    (1),
        .VPULSE (1),
        .VBP    (1),
        .HS_POL (1'b0),
        .VS_POL (1'b0),
        .GRID   (4)
    ) dut (
        .pixel_clk   (clk),
        .pixel_rst   (rst),
        .pattern_sel (pattern_sel),
        .pix_data    (pix_data),
        .pix_req     (pix_req),
        .req_x       (req_x),
        .req_y       (req_y),
        .frame_start (frame_start),
        .video_ifm   (u_vif)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          k;
    logic [1:0]  pat_of_frame [8];
    int          cap_frame;
    int          cap_row;
    logic [23:0] cap [8];
    int          hs_low, vs_low, blank_hi, blank_first, fs_cnt, fs_first, fs_second;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got %h expected %h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pixel(input logic [1:0] pat, input int x, input int y);
        logic [1:0] p;
        p = TP_EN ? pat : 2'd0;
        case (p)
            2'd0:    return 24'(x * 16 + y);
            2'd1:    return ((x % 4 == 0) || (y % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
            2'd2:    return BAR_LIT[x];
            default: return 24'h000000;
        endcase
    endfunction

    task automatic check_reset();
        check("rst_pix_req", 32'(pix_req), 32'd0);
        check("rst_req_x", 32'(req_x), 32'd0);
        check("rst_req_y", 32'(req_y), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_hs", 32'(u_vif.HS), 32'd1);
        check("rst_vs", 32'(u_vif.VS), 32'd1);
        check("rst_blank", 32'(u_vif.BLANK), 32'd0);
        check("rst_rgb", 32'(u_vif.RGB), 32'd0);
    endtask

    task automatic check_cycle();
        int   idx, h, v, f;
        logic act;
        logic [31:0] e_hs, e_vs, e_blank, e_rgb;
        act = 1'b0;
        h = 0;
        v = 0;
        if (k >= 1) begin
            idx = (k - 1) % FRAME;
            h   = idx % HT;
            v   = idx / HT;
            act = (h >= 6) && (v >= 3);
        end
        check("pix_req", 32'(pix_req), 32'(act));
        check("req_x", 32'(req_x), act ? 32'(h - 6) : 32'd0);
        check("req_y", 32'(req_y), act ? 32'(v - 3) : 32'd0);
        check("frame_start", 32'(frame_start), 32'(act && h == 6 && v == 3));

        e_hs = 32'd1; e_vs = 32'd1; e_blank = 32'd0; e_rgb = 32'd0;
        if (k >= 2) begin
            idx = (k - 2) % FRAME;
            f   = (k - 2) / FRAME;
            h   = idx % HT;
            v   = idx / HT;
            act = (h >= 6) && (v >= 3);
            e_hs    = 32'(!(h >= 2 && h < 4));
            e_vs    = 32'(v != 1);
            e_blank = 32'(act);
            e_rgb   = act ? 32'(exp_pixel(pat_of_frame[f], h - 6, v - 3)) : 32'd0;
            if (act && f == cap_frame && (v - 3) == cap_row) cap[h - 6] = u_vif.RGB;
        end
        check("hs", 32'(u_vif.HS), e_hs);
        check("vs", 32'(u_vif.VS), e_vs);
        check("blank", 32'(u_vif.BLANK), e_blank);
        check("rgb", 32'(u_vif.RGB), e_rgb);

        if (u_vif.HS === 1'b0) hs_low++;
        if (u_vif.VS === 1'b0) vs_low++;
        if (u_vif.BLANK === 1'b1) begin
            blank_hi++;
            if (blank_first < 0) blank_first = k;
        end
        if (frame_start === 1'b1) begin
            fs_cnt++;
            if (fs_cnt == 1) fs_first = k;
            else if (fs_cnt == 2) fs_second = k;
        end
    endtask

    task automatic drive();
        int idx, h, v;
        if (k % FRAME == 0) pat_of_frame[k / FRAME] = pattern_sel;
        pix_data = 24'hA5A5A5;
        if (k >= 1) begin
            idx = (k - 1) % FRAME;
            h   = idx % HT;
            v   = idx / HT;
            if (h >= 6 && v >= 3) pix_data = 24'((h - 6) * 16 + (v - 3));
        end
    endtask

    task automatic run_to(input int k_end);
        while (k < k_end) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            check_cycle();
            drive();
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 8; i++) pat_of_frame[i] = 2'd0;
        hs_low = 0; vs_low = 0; blank_hi = 0; blank_first = -1;
        fs_cnt = 0; fs_first = -1; fs_second = -1;
        cap_frame = -1;
        drive();
    endtask

    task automatic check_timing_counts();
        check("hs_low_count", 32'(hs_low), 32'd28);
        check("vs_low_count", 32'(vs_low), 32'd28);
        check("blank_high_count", 32'(blank_hi), 32'd64);
        check("blank_first_k", 32'(blank_first), 32'd50);
        check("frame_start_count", 32'(fs_cnt), 32'd2);
        check("frame_start_first_k", 32'(fs_first), 32'd49);
        check("frame_period", 32'(fs_second - fs_first), 32'd98);
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 8; i++) cap[i] = 24'h123456;
    endtask

    initial begin
        rst         = 1'b1;
        pattern_sel = 2'd0;
        pix_data    = 24'h0;
        k           = 0;
        cap_frame   = -1;
        cap_row     = 0;
        clear_cap();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        check("vif_clk_low", 32'(u_vif.CLK), 32'd0);

        release_reset();
        run_to(197);
        check_timing_counts();

        run_to(256);
        pattern_sel = 2'd2;
        clear_cap();
        cap_frame = 2;
        cap_row   = 3;
        run_to(296);
        for (int x = 0; x < 8; x++) check("ext_row3_frame2", 32'(cap[x]), 32'(x * 16 + 3));

        clear_cap();
        cap_frame = 3;
        cap_row   = 0;
        run_to(360);
        for (int x = 0; x < 8; x++)
            check("bars_row0_frame3", 32'(cap[x]), TP_EN ? 32'(BAR_LIT[x]) : 32'(x * 16));

        pattern_sel = 2'd1;
        clear_cap();
        cap_frame = 4;
        cap_row   = 1;
        run_to(470);
        for (int x = 0; x < 8; x++)
            check("grid_row1_frame4", 32'(cap[x]), TP_EN ? 32'(GRID_ROW1[x]) : 32'(x * 16 + 1));

        run_to(540);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset();

        pattern_sel = 2'd3;
        release_reset();
        run_to(197);
        check_timing_counts();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
